// File: rtl/adts_frame_parser.sv
// ADTS frame parser: finds sync, checks the 7-byte header, skips the optional CRC,
// and forwards payload bytes with a last-byte flag. Header faults are reported as error pulses.
module adts_frame_parser #(
  parameter int SYNC_TIMEOUT = 8192,
  parameter int CHANNEL_MAX  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        hdr_valid,
  output logic [1:0]  hdr_profile,
  output logic [3:0]  hdr_sf_index,
  output logic [2:0]  hdr_channel_cfg,
  output logic [12:0] hdr_frame_length,
  output logic        hdr_prot_absent,
  output logic [1:0]  hdr_num_blocks,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  input  logic        pl_ready,
  output logic        pl_last,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_SYNC2   = 3'd1,
    S_HDR     = 3'd2,
    S_CRC     = 3'd3,
    S_PAYLOAD = 3'd4
  } state_t;

  localparam int DW = $clog2(SYNC_TIMEOUT + 1);

  state_t        state_q;
  logic [DW-1:0] disc_cnt_q;
  logic [2:0]    idx_q;
  logic          sh_pa_q;
  logic [1:0]    sh_profile_q;
  logic [3:0]    sh_sf_q;
  logic [2:0]    sh_ch_q;
  logic [12:0]   sh_fl_q;
  logic [12:0]   pl_cnt_q;
  logic          hdr_valid_q;
  logic          err_valid_q;
  logic [2:0]    err_code_q;
  logic [1:0]    hdr_profile_q;
  logic [3:0]    hdr_sf_q;
  logic [2:0]    hdr_ch_q;
  logic [12:0]   hdr_fl_q;
  logic          hdr_pa_q;
  logic [1:0]    hdr_nblk_q;

  // Handshake: a byte moves when in_valid && in_ready. A payload byte moves downstream when
  // pl_valid && pl_ready, which in PAYLOAD is the same event as the upstream transfer.
  logic        pulse;
  logic        accept;
  logic [12:0] hdr_len;
  logic        sf_bad;
  logic        ch_bad;
  logic        len_bad;

  assign pulse    = hdr_valid_q | err_valid_q;
  assign in_ready = !pulse && ((state_q != S_PAYLOAD) || pl_ready);
  assign accept   = in_valid && in_ready;

  assign pl_valid = (state_q == S_PAYLOAD) && in_valid && !pulse;
  assign pl_data  = (state_q == S_PAYLOAD) ? in_data : 8'h00;
  assign pl_last  = pl_valid && (pl_cnt_q == 13'd1);

  assign hdr_len = sh_pa_q ? 13'd7 : 13'd9;
  assign sf_bad  = (sh_sf_q >= 4'd13);
  assign ch_bad  = (sh_ch_q == 3'd0) || (sh_ch_q > 3'(CHANNEL_MAX));
  assign len_bad = (sh_fl_q <= hdr_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_HUNT;
      disc_cnt_q    <= '0;
      idx_q         <= 3'd0;
      sh_pa_q       <= 1'b0;
      sh_profile_q  <= 2'd0;
      sh_sf_q       <= 4'd0;
      sh_ch_q       <= 3'd0;
      sh_fl_q       <= 13'd0;
      pl_cnt_q      <= 13'd0;
      hdr_valid_q   <= 1'b0;
      err_valid_q   <= 1'b0;
      err_code_q    <= 3'd0;
      hdr_profile_q <= 2'd0;
      hdr_sf_q      <= 4'd0;
      hdr_ch_q      <= 3'd0;
      hdr_fl_q      <= 13'd0;
      hdr_pa_q      <= 1'b0;
      hdr_nblk_q    <= 2'd0;
    end else begin
      hdr_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      if (accept) begin
        case (state_q)
          S_HUNT: begin
            if (in_data == 8'hFF) begin
              state_q    <= S_SYNC2;
              disc_cnt_q <= '0;
            end else if (disc_cnt_q == DW'(SYNC_TIMEOUT - 1)) begin
              err_valid_q <= 1'b1;
              err_code_q  <= 3'd4;
              disc_cnt_q  <= '0;
            end else begin
              disc_cnt_q <= disc_cnt_q + 1'b1;
            end
          end
          S_SYNC2: begin
            // A run of 0xFF keeps us aligned on the last one as the sync start.
            if (in_data == 8'hFF) begin
              state_q <= S_SYNC2;
            end else if (in_data[7:4] != 4'hF) begin
              state_q <= S_HUNT;
            end else if (in_data[2:1] != 2'b00) begin
              err_valid_q <= 1'b1;
              err_code_q  <= 3'd1;
              state_q     <= S_HUNT;
            end else begin
              sh_pa_q <= in_data[0];
              idx_q   <= 3'd2;
              state_q <= S_HDR;
            end
          end
          S_HDR: begin
            idx_q <= idx_q + 3'd1;
            case (idx_q)
              3'd2: begin
                sh_profile_q <= in_data[7:6];
                sh_sf_q      <= in_data[5:2];
                sh_ch_q[2]   <= in_data[0];
              end
              3'd3: begin
                sh_ch_q[1:0]   <= in_data[7:6];
                sh_fl_q[12:11] <= in_data[1:0];
              end
              3'd4: sh_fl_q[10:3] <= in_data;
              3'd5: sh_fl_q[2:0]  <= in_data[7:5];
              default: begin
                idx_q <= 3'd0;
                if (sf_bad) begin
                  err_valid_q <= 1'b1;
                  err_code_q  <= 3'd2;
                  state_q     <= S_HUNT;
                end else if (ch_bad) begin
                  err_valid_q <= 1'b1;
                  err_code_q  <= 3'd3;
                  state_q     <= S_HUNT;
                end else if (len_bad) begin
                  err_valid_q <= 1'b1;
                  err_code_q  <= 3'd5;
                  state_q     <= S_HUNT;
                end else begin
                  hdr_valid_q   <= 1'b1;
                  hdr_profile_q <= sh_profile_q;
                  hdr_sf_q      <= sh_sf_q;
                  hdr_ch_q      <= sh_ch_q;
                  hdr_fl_q      <= sh_fl_q;
                  hdr_pa_q      <= sh_pa_q;
                  hdr_nblk_q    <= in_data[1:0];
                  // len_bad already excluded, so the payload count is at least 1.
                  pl_cnt_q      <= sh_fl_q - hdr_len;
                  state_q       <= sh_pa_q ? S_PAYLOAD : S_CRC;
                end
              end
            endcase
          end
          S_CRC: begin
            if (idx_q == 3'd1) begin
              idx_q   <= 3'd0;
              state_q <= S_PAYLOAD;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
          S_PAYLOAD: begin
            pl_cnt_q <= pl_cnt_q - 13'd1;
            if (pl_cnt_q == 13'd1) begin
              state_q <= S_HUNT;
            end
          end
          default: state_q <= S_HUNT;
        endcase
      end
    end
  end

  assign hdr_valid        = hdr_valid_q;
  assign hdr_profile      = hdr_profile_q;
  assign hdr_sf_index     = hdr_sf_q;
  assign hdr_channel_cfg  = hdr_ch_q;
  assign hdr_frame_length = hdr_fl_q;
  assign hdr_prot_absent  = hdr_pa_q;
  assign hdr_num_blocks   = hdr_nblk_q;
  assign err_valid        = err_valid_q;
  assign err_code         = err_code_q;
  assign dbg_state        = state_q;

endmodule
